// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB master bridge.
// Optional ACCESS-phase timeout is enabled with the APB_BRIDGE_TIMEOUT_EN macro.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_bridge_state_e;

  // Read data returned alongside a timeout error.
  localparam int unsigned TIMEOUT_ERR_DATA = 0;

endpackage

// File: rtl/apb_bridge_timeout_cnt.sv
// Counts ACCESS cycles and flags the terminal count of an APB transfer.
// Only instantiated when APB_BRIDGE_TIMEOUT_EN is defined.
module apb_bridge_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // The first ACCESS cycle sees count 0, so the last allowed cycle is TIMEOUT_CYCLES-1.
  assign expired_o = (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (clear_i) begin
      count_reg <= '0;
    end else if (enable_i && !expired_o) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response port to APB master bridge.
// Define APB_BRIDGE_TIMEOUT_EN to abort ACCESS phases after TIMEOUT_CYCLES cycles.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic                  pwrite_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_bridge_state_e state_reg;
  apb_bridge_state_e state_next;

  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic                  pwrite_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  opc_reg;
  logic                  timeout_hit;

`ifdef APB_BRIDGE_TIMEOUT_EN
  // SETUP always precedes ACCESS, so clearing there resets the count on ACCESS entry.
  apb_bridge_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_reg == ST_SETUP),
    .enable_i (state_reg == ST_ACCESS),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Reset forces IDLE asynchronously, so the grant must also be masked by rst_i.
  assign gnt_o = req_i && (state_reg == ST_IDLE) && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (gnt_o) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (pready_i || timeout_hit) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_o    = 1'b0;
    penable_o = 1'b0;
    r_valid_o = 1'b0;
    busy_o    = 1'b1;
    case (state_reg)
      ST_IDLE:   busy_o = 1'b0;
      ST_SETUP:  psel_o = 1'b1;
      ST_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      ST_RESP:   r_valid_o = 1'b1;
      default:   busy_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      paddr_reg  <= '0;
      pwdata_reg <= '0;
      pwrite_reg <= 1'b0;
      rdata_reg  <= '0;
      opc_reg    <= 1'b0;
    end else begin
      if (gnt_o) begin
        paddr_reg  <= addr_i;
        pwdata_reg <= wdata_i;
        pwrite_reg <= we_i;
      end
      if (state_reg == ST_ACCESS) begin
        if (pready_i) begin
          rdata_reg <= pwrite_reg ? '0 : prdata_i;
          opc_reg   <= pslverr_i;
        end else if (timeout_hit) begin
          rdata_reg <= DATA_WIDTH'(TIMEOUT_ERR_DATA);
          opc_reg   <= 1'b1;
        end
      end
    end
  end

  assign paddr_o   = paddr_reg;
  assign pwdata_o  = pwdata_reg;
  assign pwrite_o  = pwrite_reg;
  assign r_rdata_o = rdata_reg;
  assign r_opc_o   = opc_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed, table-driven bench for apb_master_bridge with a small APB slave responder.
// Extra timeout sequences are exercised when APB_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          ws;
    logic [31:0] exp_rdata;
    logic        exp_opc;
    int          exp_lat;
    int          exp_sel;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic        busy;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .addr_i   (addr),
    .we_i     (we),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .r_valid_o(r_valid),
    .r_rdata_o(r_rdata),
    .r_opc_o  (r_opc),
    .busy_o   (busy),
    .paddr_o  (paddr),
    .pwdata_o (pwdata),
    .pwrite_o (pwrite),
    .psel_o   (psel),
    .penable_o(penable),
    .prdata_i (prdata),
    .pready_i (pready),
    .pslverr_i(pslverr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge with the bridge idle; returns just after a falling edge.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc = 0;
    int acc = 0;
    int sel = 0;
    int bad = 0;
    bit done = 0;
    req = 1'b1; addr = v.addr; we = v.we; wdata = v.wdata;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_gnt"}, {31'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; addr = 32'h0; wdata = 32'h0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (psel) begin
        sel++;
        if (paddr !== v.addr || pwrite !== v.we || (v.we && pwdata !== v.wdata)) bad++;
      end
      if (psel && penable) begin
        acc++;
        pready  = (acc > v.ws);
        pslverr = v.slverr;
        prdata  = v.prdata;
      end else begin
        // Junk completion outside ACCESS must be ignored.
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_BEEF;
      end
      if (r_valid) begin
        done = 1;
        chk({tag, "_lat"},   cyc, v.exp_lat);
        chk({tag, "_rdata"}, r_rdata, v.exp_rdata);
        chk({tag, "_opc"},   {31'd0, r_opc}, {31'd0, v.exp_opc});
        chk({tag, "_sel"},   sel, v.exp_sel);
        chk({tag, "_stable"}, bad, 0);
        $display("txn %s we=%0d addr=%08h lat=%0d rdata=%08h opc=%0d", tag, v.we, v.addr, cyc,
                 r_rdata, r_opc);
      end else if (cyc > 60) begin
        done = 1;
        chk({tag, "_rvalid_seen"}, 32'd0, 32'd1);
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, r_valid}, 32'd0);
    chk({tag, "_idle"},  {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int g1;
    int g2;
    int gnt_busy;
    int seen;
    vec_t v;

    vecs[0] = '{1'b1, 32'h1A10_0004, 32'hCAFE_F00D, 32'h5555_AAAA, 1'b0, 0,
                32'h0000_0000, 1'b0, 3, 2};
    vecs[1] = '{1'b0, 32'h4000_0010, 32'h0, 32'h1234_5678, 1'b0, 3,
                32'h1234_5678, 1'b0, 6, 5};
    vecs[2] = '{1'b0, 32'h4000_0020, 32'h0, 32'hA5A5_0F0F, 1'b1, 1,
                32'hA5A5_0F0F, 1'b1, 4, 3};
    vecs[3] = '{1'b1, 32'h4000_0030, 32'h0BAD_CAFE, 32'h1111_2222, 1'b1, 2,
                32'h0000_0000, 1'b1, 5, 4};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 1'b0, 0,
                32'h0000_0000, 1'b0, 3, 2};
`ifdef APB_BRIDGE_TIMEOUT_EN
    // pready arrives in the terminal count cycle: normal completion wins.
    vecs[5] = '{1'b0, 32'h4000_0050, 32'h0, 32'h7777_8888, 1'b0, 7,
                32'h7777_8888, 1'b0, 10, 9};
`else
    // Long stall with no timeout: bridge just waits in ACCESS.
    vecs[5] = '{1'b0, 32'h4000_0050, 32'h0, 32'h7777_8888, 1'b0, 20,
                32'h7777_8888, 1'b0, 23, 22};
`endif

    rst = 1'b1; req = 1'b1; addr = 32'h1234_0000; we = 1'b1; wdata = 32'hFFFF_FFFF;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",     {31'd0, gnt}, 32'd0);
    chk("rst_psel",    {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_rvalid",  {31'd0, r_valid}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_opc",     {31'd0, r_opc}, 32'd0);
    chk("rst_rdata",   r_rdata, 32'd0);
    chk("rst_paddr",   paddr, 32'd0);
    chk("rst_pwdata",  pwdata, 32'd0);
    chk("rst_pwrite",  {31'd0, pwrite}, 32'd0);
    rst = 1'b0; req = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: request held across two transactions.
    req = 1'b1; addr = 32'h5000_0000; we = 1'b1; wdata = 32'h0102_0304;
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
    g1 = -1; g2 = -1; gnt_busy = 0;
    for (int c = 0; c < 20 && g2 < 0; c++) begin
      #1;
      if (gnt) begin
        if (g1 < 0) g1 = c;
        else g2 = c;
      end
      if (gnt && busy) gnt_busy++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    chk("b2b_first",   g1, 0);
    chk("b2b_spacing", g2 - g1, 4);
    chk("b2b_gnt_busy", gnt_busy, 0);
    $display("txn b2b first_gnt=%0d second_gnt=%0d", g1, g2);
    pready = 1'b0;
    @(negedge clk);

    // Reset pulsed during ACCESS drops the transaction with no response.
    req = 1'b1; addr = 32'h6000_0000; we = 1'b0; pready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 5 && !penable; k++) @(negedge clk);
    chk("rstmid_in_access", {31'd0, penable}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_psel",    {31'd0, psel}, 32'd0);
    chk("rstmid_penable", {31'd0, penable}, 32'd0);
    chk("rstmid_busy",    {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; pready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (r_valid) seen++;
    end
    chk("rstmid_no_resp", seen, 0);
    pready = 1'b0;
    $display("txn rst_during_access dropped");
    run_vec("after_rst", vecs[0]);

`ifdef APB_BRIDGE_TIMEOUT_EN
    v = '{1'b0, 32'h4000_0060, 32'h0, 32'hABCD_EF01, 1'b0, 1000,
          32'h0000_0000, 1'b1, 10, 9};
    run_vec("timeout", v);
`else
    v = vecs[1];
    run_vec("reread", v);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got stuck expected done");
    $fatal(1, "global timeout");
  end

endmodule
